wb_gcd_accel: RTL

WB_GCD_ACCEL -- requirements
Module: wb_gcd_accel

---
 rtl/wb_gcd_accel.sv | 355 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_gcd_accel.sv
// -----------------------------------------------------------------------------
// wb_gcd_accel -- Wishbone-attached greatest-common-divisor accelerator.
//
// Software writes operand A to OPA and then operand B to OPB. The OPB write
// queues the pair in a request FIFO. A subtract-and-swap engine drains that
// FIFO one pair at a time and queues each gcd in a result FIFO, which
// software pops by reading RESULT. Results come back in request order.
//
// Register map (word offsets, wbs_adr_i[4:2]):
//   0 OPA     R/W  operand A latch
//   1 OPB     W    push {OPA, data} into the request FIFO (dropped + OVF if full)
//   2 RESULT  R    pop one result (0 and UDF if the FIFO is empty)
//   3 STATUS  R/W1C [0] req_empty [1] req_full [2] res_empty [3] res_full
//                   [4] busy [5] OVF [6] UDF [12:8] result count
//   4 CTRL    R/W  [0] irq enable, [1] overflow-irq enable (optional feature)
//   Other offsets read 0; writes to them are acknowledged and ignored.
//
// Optional feature macro: GCD_ACCEL_IRQ_EN
//   defined   -> CTRL is implemented and irq_o =
//                (CTRL[0] & ~res_empty) | (CTRL[1] & OVF)
//   undefined -> CTRL reads 0, writes are ignored, irq_o is tied low.
//
// Ports:
//   wb_clk_i    sole clock, all state on its rising edge
//   wb_rst_ni   asynchronous active-low reset
//   wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i (ignored), wbs_adr_i, wbs_dat_i
//               Wishbone slave inputs
//   wbs_ack_o   registered single-cycle acknowledge
//   wbs_dat_o   registered read data
//   irq_o       level interrupt
//   busy_o      high while the engine is not IDLE
//
// Parameters: WIDTH (2..32) operand/result width, DEPTH (power of two, 2..16)
// depth of each FIFO.
// -----------------------------------------------------------------------------
module wb_gcd_accel #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] ADR_OPA    = 3'd0;
  localparam logic [2:0] ADR_OPB    = 3'd1;
  localparam logic [2:0] ADR_RESULT = 3'd2;
  localparam logic [2:0] ADR_STATUS = 3'd3;
  localparam logic [2:0] ADR_CTRL   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic                 r_ack;
  logic [31:0]          r_dat;
  logic [WIDTH-1:0]     r_opa;
  logic                 r_ovf;
  logic                 r_udf;

  logic [2*WIDTH-1:0]   r_rq_mem [DEPTH];
  logic [PW-1:0]        r_rq_wp;
  logic [PW-1:0]        r_rq_rp;
  logic [CW-1:0]        r_rq_cnt;

  logic [WIDTH-1:0]     r_rs_mem [DEPTH];
  logic [PW-1:0]        r_rs_wp;
  logic [PW-1:0]        r_rs_rp;
  logic [CW-1:0]        r_rs_cnt;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;

  logic                 w_valid;
  logic                 w_acc;
  logic                 w_wr;
  logic                 w_rd;
  logic [2:0]           w_off;
  logic                 w_opa_wr;
  logic                 w_stat_wr;
  logic                 w_res_rd;
  logic [31:0]          w_rdata;

  logic                 w_rq_push_req;
  logic                 w_rq_push;
  logic                 w_rq_pop;
  logic                 w_rq_empty;
  logic                 w_rq_full;
  logic [2*WIDTH-1:0]   w_rq_head;

  logic                 w_rs_push;
  logic                 w_rs_pop;
  logic                 w_rs_empty;
  logic                 w_rs_full;

  logic                 w_load;
  logic                 w_swap;
  logic                 w_sub;

  // Byte selects and the undecoded address/data bits carry no meaning here.
  logic                 w_unused;
  assign w_unused = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  // An access is taken only when no ack is pending, so a master that holds
  // stb across the ack cycle is serviced once per ack and ack never repeats
  // on consecutive cycles.
  assign w_valid       = wbs_cyc_i & wbs_stb_i;
  assign w_acc         = w_valid & ~r_ack;
  assign w_wr          = w_acc & wbs_we_i;
  assign w_rd          = w_acc & ~wbs_we_i;
  assign w_off         = wbs_adr_i[4:2];
  assign w_opa_wr      = w_wr & (w_off == ADR_OPA);
  assign w_rq_push_req = w_wr & (w_off == ADR_OPB);
  assign w_stat_wr     = w_wr & (w_off == ADR_STATUS);
  assign w_res_rd      = w_rd & (w_off == ADR_RESULT);

  assign w_rq_empty = (r_rq_cnt == '0);
  assign w_rq_full  = (r_rq_cnt == FULL_CNT);
  assign w_rs_empty = (r_rs_cnt == '0);
  assign w_rs_full  = (r_rs_cnt == FULL_CNT);
  assign w_rq_head  = r_rq_mem[r_rq_rp];

  // A push into a full request FIFO still succeeds when the engine pops in
  // the same cycle.
  assign w_rq_push = w_rq_push_req & (~w_rq_full | w_rq_pop);
  assign w_rs_pop  = w_res_rd & ~w_rs_empty;

`ifdef GCD_ACCEL_IRQ_EN
  logic [1:0] r_ctrl;
  logic       w_ctrl_wr;
  assign w_ctrl_wr = w_wr & (w_off == ADR_CTRL);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ctrl <= '0;
    end else if (w_ctrl_wr) begin
      r_ctrl <= wbs_dat_i[1:0];
    end
  end

  assign irq_o = (r_ctrl[0] & ~w_rs_empty) | (r_ctrl[1] & r_ovf);
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_off)
      ADR_OPA:    w_rdata = zext(r_opa);
      ADR_RESULT: w_rdata = w_rs_empty ? 32'd0 : zext(r_rs_mem[r_rs_rp]);
      ADR_STATUS: begin
        w_rdata[0]    = w_rq_empty;
        w_rdata[1]    = w_rq_full;
        w_rdata[2]    = w_rs_empty;
        w_rdata[3]    = w_rs_full;
        w_rdata[4]    = busy_o;
        w_rdata[5]    = r_ovf;
        w_rdata[6]    = r_udf;
        w_rdata[12:8] = 5'(r_rs_cnt);
      end
`ifdef GCD_ACCEL_IRQ_EN
      ADR_CTRL:   w_rdata[1:0] = r_ctrl;
`endif
      default:    w_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus response and software-visible registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_opa <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : 32'd0;
      if (w_opa_wr) begin
        r_opa <= wbs_dat_i[WIDTH-1:0];
      end
      if (w_rq_push_req & ~w_rq_push) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr & wbs_dat_i[5]) begin
        r_ovf <= 1'b0;
      end
      if (w_res_rd & w_rs_empty) begin
        r_udf <= 1'b1;
      end else if (w_stat_wr & wbs_dat_i[6]) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  // ---------------------------------------------------------------------------
  // Request FIFO: {A, B} pairs from the bus to the engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (w_rq_push) begin
      r_rq_mem[r_rq_wp] <= {r_opa, wbs_dat_i[WIDTH-1:0]};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rq_wp  <= '0;
      r_rq_rp  <= '0;
      r_rq_cnt <= '0;
    end else begin
      if (w_rq_push) begin
        r_rq_wp <= r_rq_wp + PW'(1);
      end
      if (w_rq_pop) begin
        r_rq_rp <= r_rq_rp + PW'(1);
      end
      case ({w_rq_push, w_rq_pop})
        2'b10:   r_rq_cnt <= r_rq_cnt + CW'(1);
        2'b01:   r_rq_cnt <= r_rq_cnt - CW'(1);
        default: r_rq_cnt <= r_rq_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO: gcd values from the engine to the bus
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (w_rs_push) begin
      r_rs_mem[r_rs_wp] <= r_a;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rs_wp  <= '0;
      r_rs_rp  <= '0;
      r_rs_cnt <= '0;
    end else begin
      if (w_rs_push) begin
        r_rs_wp <= r_rs_wp + PW'(1);
      end
      if (w_rs_pop) begin
        r_rs_rp <= r_rs_rp + PW'(1);
      end
      case ({w_rs_push, w_rs_pop})
        2'b10:   r_rs_cnt <= r_rs_cnt + CW'(1);
        2'b01:   r_rs_cnt <= r_rs_cnt - CW'(1);
        default: r_rs_cnt <= r_rs_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In CALC the larger operand is always kept in A; once B reaches zero, A
  // holds the gcd, which also covers gcd(x,0)=x and gcd(0,0)=0.
  always_comb begin
    w_state_nxt = r_state;
    w_rq_pop    = 1'b0;
    w_rs_push   = 1'b0;
    w_load      = 1'b0;
    w_swap      = 1'b0;
    w_sub       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rq_empty) begin
          w_rq_pop    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_a < r_b) begin
          w_swap = 1'b1;
        end else if (r_b != '0) begin
          w_sub = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!w_rs_full) begin
          w_rs_push   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Engine datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_load) begin
      r_a <= w_rq_head[2*WIDTH-1:WIDTH];
      r_b <= w_rq_head[WIDTH-1:0];
    end else if (w_swap) begin
      r_a <= r_b;
      r_b <= r_a;
    end else if (w_sub) begin
      r_a <= r_a - r_b;
    end
  end

endmodule
